egress_queue: RTL
=================

Name: egress_queue

Overview:
- Downstream neighbour of the switch side. Consumes the side's internal write bus (one-hot write-enable plus a shared data word) and queues each word in one of four per-device FIFOs.
- Drains each FIFO to its target device over a valid/ack handshake.
- Returns per-lane full status to the side for flow control, and flags any word dropped because its lane overflowed.

Parameters:
- DW, 4, data width of one word.
- DEPTH, 2, entries per lane FIFO; must be ≥1.
- SLACK, 0, headroom: full_o[k] asserts when occupancy ≥ DEPTH-SLACK (covers in-flight writes); 0 ≤ SLACK < DEPTH.

Ports:
- clk_i  in  1  clock, all flops on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- int_wen_i  in  4  per-lane write enable from the side (normally one-hot)
- int_dat_i  in  DW  shared write data
- full_o  in→out  4  per-lane full / backpressure to the side
- validrx_0..validrx_3  out  1 each  lane k has a word for device k
- dat_o_0..dat_o_3  out  DW each  head word of lane k
- ackrx_0..ackrx_3  in  1 each  device k accepts the head word
- ovf_o  out  4  sticky per-lane overflow flag
- cnt_o  out  4*CW  per-lane occupancy, lane k at [k*CW +: CW], CW=$clog2(DEPTH+1)

Behaviour:
- Reset (rst_i=0, async): all lanes empty, pointers 0. validrx_k=0, dat_o_k=0, full_o=4'h0 (or per-lane 1 when DEPTH-SLACK==0 is impossible), ovf_o=0, cnt_o=0. Reset mid-operation discards all queued words immediately, without waiting for a clock.
- Lanes are fully independent. Each lane is a circular buffer: wr_ptr, rd_ptr in [0, DEPTH-1] wrapping to 0 after DEPTH-1, and cnt in [0, DEPTH].
- Push: int_wen_i[k]=1 at an edge. Multi-hot int_wen_i writes int_dat_i into every flagged lane (broadcast); int_wen_i=0 is idle.
- Pop: validrx_k & ackrx_k at an edge. ackrx_k while validrx_k=0 is ignored.
- Per-lane update at each edge:
  - push only, cnt<DEPTH: store at wr_ptr, wr_ptr++, cnt++.
  - push only, cnt==DEPTH: word dropped, state unchanged, ovf_o[k] set to 1. It stays 1 until reset.
  - pop only: rd_ptr++, cnt--.
  - push and pop, any cnt ≥1 including full: both happen, cnt unchanged, no overflow. The pushed word is never the popped word.
  - push when cnt==0 and pop impossible: cnt becomes 1.
- Outputs:
  - validrx_k = (cnt!=0).
  - dat_o_k = mem[rd_ptr] when cnt!=0, else 0.
  - Both are driven from registered state (no combinational path from int_wen_i or ackrx).
- Latency: a word pushed at edge N is visible on validrx_k/dat_o_k in cycle N+1. Pop at edge M presents the next word in cycle M+1.
- Handshake: validrx_k and dat_o_k stay stable until the cycle ack is sampled. A device may hold ackrx_k high continuously, giving one word per cycle throughput.
- full_o[k] = (cnt ≥ DEPTH-SLACK), a function of registered cnt only. The side samples it with pipeline delay, so SLACK must cover its in-flight writes; any excess beyond that is caught by ovf_o.
- Ordering: strict FIFO per lane. No ordering between lanes.

Test Plan:
- Reset release, then push lane 2 with int_wen_i=4'h4, int_dat_i=4'hA, ackrx_2=0 → next cycle validrx_2=1, dat_o_2=A, cnt lane2=1, other lanes idle.
- DEPTH=2, SLACK=0: push lane 0 with 3, then 5, then 7, no ack → full_o[0]=1 after the second push; 7 is dropped and ovf_o[0]=1. Then ack twice → dat_o_0 shows 3 then 5, then validrx_0=0. ovf_o[0] remains 1.
- Lane 1 full (words 1, 2), same edge push 9 and ackrx_1=1 → cnt stays 2, ovf_o[1]=0. Output sequence is 2 then 9.
- ackrx_3 held high, four consecutive pushes B, C, D, E → dat_o_3 shows B, C, D, E in consecutive cycles. Pointers wrap with no loss.
- int_wen_i=4'hF, int_dat_i=6 → all four lanes get 6 and all validrx=1.
- Queue words in lanes 0 and 3, then assert rst_i=0 between edges → validrx, cnt_o and ovf_o clear immediately. After release, the first push appears correctly.
- SLACK=1, DEPTH=2: one push → full_o=1 while cnt=1 and validrx=1.

Source files
------------

// File: rtl/egress_queue.sv
// egress_queue
//   Takes words from the switch side's internal write bus and queues each one
//   in one of four independent per-device FIFOs. Each FIFO is drained to its
//   device over a valid/ack handshake. Per-lane full status goes back to the
//   side for flow control. A sticky flag records any word dropped because
//   its lane was full.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 asynchronous reset, active low
//   int_wen_i[3:0]        per-lane write enable (multi-hot broadcasts)
//   int_dat_i[DW-1:0]     shared write data
//   full_o[3:0]           lane occupancy >= DEPTH-SLACK
//   validrx_k             lane k holds at least one word
//   dat_o_k[DW-1:0]       head word of lane k (0 when empty)
//   ackrx_k               device k takes the head word
//   ovf_o[3:0]            sticky per-lane overflow flag
//   cnt_o[4*CW-1:0]       per-lane occupancy, lane k at [k*CW +: CW]
module egress_queue #(
  parameter int DW    = 4,
  parameter int DEPTH = 2,
  parameter int SLACK = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [3:0]                     int_wen_i,
  input  logic [DW-1:0]                  int_dat_i,
  output logic [3:0]                     full_o,
  output logic                           validrx_0,
  output logic                           validrx_1,
  output logic                           validrx_2,
  output logic                           validrx_3,
  output logic [DW-1:0]                  dat_o_0,
  output logic [DW-1:0]                  dat_o_1,
  output logic [DW-1:0]                  dat_o_2,
  output logic [DW-1:0]                  dat_o_3,
  input  logic                           ackrx_0,
  input  logic                           ackrx_1,
  input  logic                           ackrx_2,
  input  logic                           ackrx_3,
  output logic [3:0]                     ovf_o,
  output logic [4*$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  // Pointers need at least one bit even for a single-entry lane.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]      ack_s;
  logic [3:0]      valid_s;
  logic [4*DW-1:0] head_s;

  assign ack_s = {ackrx_3, ackrx_2, ackrx_1, ackrx_0};

  assign validrx_0 = valid_s[0];
  assign validrx_1 = valid_s[1];
  assign validrx_2 = valid_s[2];
  assign validrx_3 = valid_s[3];
  assign dat_o_0   = head_s[0*DW +: DW];
  assign dat_o_1   = head_s[1*DW +: DW];
  assign dat_o_2   = head_s[2*DW +: DW];
  assign dat_o_3   = head_s[3*DW +: DW];

  // Circular pointer advance, wrapping after the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  genvar k;
  for (k = 0; k < 4; k++) begin : g_lane
    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          ovf_r;
    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;

    // Handshake decode. A push into a full lane is accepted only when the
    // same edge frees a slot; the freed slot is the one being written, and
    // the popped word is read out before it is overwritten.
    always_comb begin
      push_s  = int_wen_i[k];
      pop_s   = (cnt_r != {CW{1'b0}}) & ack_s[k];
      wr_en_s = push_s & ((cnt_r != CW'(DEPTH)) | pop_s);
    end

    // Lane storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_r[i] <= {DW{1'b0}};
        end
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        cnt_r    <= {CW{1'b0}};
        ovf_r    <= 1'b0;
      end else begin
        if (wr_en_s) begin
          mem_r[wr_ptr_r] <= int_dat_i;
          wr_ptr_r        <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
        if (wr_en_s & ~pop_s) begin
          cnt_r <= cnt_r + CW'(1);
        end else if (pop_s & ~push_s) begin
          cnt_r <= cnt_r - CW'(1);
        end
        if (push_s & ~wr_en_s) begin
          ovf_r <= 1'b1;
        end
      end
    end

    assign valid_s[k]            = (cnt_r != {CW{1'b0}});
    assign head_s[k*DW +: DW]    = (cnt_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {DW{1'b0}};
    assign full_o[k]             = (cnt_r >= CW'(DEPTH - SLACK));
    assign ovf_o[k]              = ovf_r;
    assign cnt_o[k*CW +: CW]     = cnt_r;
  end

endmodule
